vi_slot_scheduler: RTL

Time-slot controller for the VI strobe path. Derives slot and frame timing from the 320 kHz reference input i320, which is asynchronous to clk. Shares each slot among N_REQ channel requesters by registered round-robin arbitration. Produces a gated VI waveform that is blanked during the final reference period of every slot.

---
 rtl/vi_slot_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/vi_slot_scheduler.sv
// Slot/frame timing derived from the asynchronous 320 kHz reference, with round-robin
// slot grants and a VI gate blanked in the last reference period. Optional watchdog: VI_SCHED_WATCHDOG_EN.
module vi_slot_scheduler #(
  parameter int N_REQ   = 4,
  parameter int PERIOD  = 40,
  parameter int SLOTS   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i320,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic                     slot_stb,
  output logic                     frame_stb,
  output logic [$clog2(SLOTS)-1:0] slot_idx,
  output logic                     vi_gate,
  output logic                     busy,
  output logic                     lost
);

  localparam int SLOT_W = $clog2(SLOTS);
  localparam int TICK_W = $clog2(PERIOD);
  localparam int PTR_W  = $clog2(N_REQ);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PERIOD - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [PTR_W-1:0]  PTR_INIT  = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                s1;
  logic                s2;
  logic                rise;
  logic                timeout;
  logic [TICK_W-1:0]   tick_cnt;
  logic [TICK_W-1:0]   tick_nxt;
  logic [SLOT_W-1:0]   slot_nxt;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic                stb_nxt;
  logic                frame_nxt;
  logic                vi_nxt;
  logic                busy_nxt;
  logic                lost_nxt;
  logic                arb;
  logic                arb_found;
  logic [PTR_W-1:0]    arb_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i320;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

`ifdef VI_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;

  // Counts clk cycles in RUN since the last reference edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if ((state != RUN) || rise) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (state == RUN) && !rise && (wd_cnt == WD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search starting one past the last winner
  always_comb begin
    arb_found = 1'b0;
    arb_win   = ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!arb_found && req[(int'(ptr) + k) % N_REQ]) begin
        arb_found = 1'b1;
        arb_win   = PTR_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    slot_nxt  = slot_idx;
    grant_nxt = grant;
    stb_nxt   = 1'b0;
    frame_nxt = 1'b0;
    lost_nxt  = lost;
    arb       = 1'b0;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        tick_nxt  = '0;
        slot_nxt  = '0;
        grant_nxt = '0;
        lost_nxt  = 1'b0;
        if (en) state_nxt = SYNC;
        else    state_nxt = IDLE;
      end
      SYNC: begin
        if (!en) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          slot_nxt  = '0;
          grant_nxt = '0;
          lost_nxt  = 1'b0;
        end else if (rise) begin
          state_nxt = RUN;
          tick_nxt  = '0;
          slot_nxt  = '0;
          stb_nxt   = 1'b1;
          frame_nxt = 1'b1;
          arb       = 1'b1;
        end else begin
          state_nxt = SYNC;
        end
      end
      RUN: begin
        // en has priority over a coincident slot boundary
        if (!en) begin
          state_nxt = IDLE;
          tick_nxt  = '0;
          slot_nxt  = '0;
          grant_nxt = '0;
          lost_nxt  = 1'b0;
        end else if (rise) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt = '0;
            if (slot_idx == SLOT_LAST) slot_nxt = '0;
            else                       slot_nxt = slot_idx + SLOT_W'(1);
            stb_nxt   = 1'b1;
            frame_nxt = (slot_idx == SLOT_LAST);
            arb       = 1'b1;
          end else begin
            tick_nxt = tick_cnt + TICK_W'(1);
          end
        end else if (timeout) begin
          state_nxt = SYNC;
          tick_nxt  = '0;
          slot_nxt  = '0;
          grant_nxt = '0;
          lost_nxt  = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        tick_nxt  = '0;
        slot_nxt  = '0;
        grant_nxt = '0;
        lost_nxt  = 1'b0;
      end
    endcase

    if (arb && arb_found) begin
      grant_nxt = ONE_HOT0 << arb_win;
      ptr_nxt   = arb_win;
    end else if (arb) begin
      grant_nxt = '0;
    end else begin
      ptr_nxt = ptr;
    end

    // s1 is the value s2 takes at this edge, so the registered gate tracks s2
    vi_nxt   = (state_nxt == RUN) && s1 && (tick_nxt != TICK_LAST);
    busy_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt  <= '0;
      slot_idx  <= '0;
      ptr       <= PTR_INIT;
      grant     <= '0;
      slot_stb  <= 1'b0;
      frame_stb <= 1'b0;
      vi_gate   <= 1'b0;
      busy      <= 1'b0;
      lost      <= 1'b0;
    end else begin
      tick_cnt  <= tick_nxt;
      slot_idx  <= slot_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      slot_stb  <= stb_nxt;
      frame_stb <= frame_nxt;
      vi_gate   <= vi_nxt;
      busy      <= busy_nxt;
      lost      <= lost_nxt;
    end
  end

endmodule
